// File: rtl/l2_arbiter_pkg.sv
// l2_arbiter_pkg
// Shared types and sizes for the L2 request arbiter and its grant sub-module.
//   arb_state_e : transaction FSM states
//   owner_e     : which cache owns the current transaction (I = 0, D = 1)
//   BLOCK_ADDRESS_WIDTH / BLOCK_WIDTH : default block address and block data widths
package l2_arbiter_pkg;

    localparam int BLOCK_ADDRESS_WIDTH = 26;   // 32-bit byte address minus 6 offset bits
    localparam int BLOCK_WIDTH         = 512;  // 16 words x 32 bits

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RESP,
        DELIVER
    } arb_state_e;

    typedef enum logic {
        OWNER_I = 1'b0,
        OWNER_D = 1'b1
    } owner_e;

endpackage

// File: rtl/round_robin_grant_2.sv
// round_robin_grant_2
// Two-requester round-robin grant. On a tie the requester that was not granted
// last wins; a lone requester always wins. The last-grant record only moves
// when update is asserted, so a grant that is offered but not taken does not
// disturb the fairness order.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (last grant resets to D)
//   req[1:0] : request vector, index 0 = I-cache, index 1 = D-cache
//   update   : a grant was taken this cycle; record it as the last grant
//   grant    : one-hot grant (or zero when nothing requests)
module round_robin_grant_2
    import l2_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       update,
    output logic [1:0] grant
);

    owner_e last_grant;

    // NOTE: state registers use non-blocking (<=) so every flop samples the
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWNER_D;
        end else if (update) begin
            last_grant <= grant[1] ? OWNER_D : OWNER_I;
        end
    end

    // NOTE: grant is assigned a default before any branch; without it the
    // combinational block would have paths that leave grant unassigned and
    // synthesis would infer a latch.
    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = (last_grant == OWNER_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/l2_request_arbiter.sv
// l2_request_arbiter
// Shares the single L2 port between the I-cache and the D-cache. One L2
// transaction is outstanding at a time: a request is accepted in IDLE, issued
// to L2 in ISSUE, a read waits for its block in WAIT_RESP and hands it to the
// owning cache in DELIVER. D-cache write-backs finish as soon as L2 accepts them.
// Ports:
//   clk, rst                                : clock, asynchronous active-high reset
//   addr_valid_i/addr_ready_i/addr_i        : I-cache request channel
//   data_valid_i/data_ready_i/data_i        : I-cache fill channel
//   addr_valid_d/addr_ready_d/addr_d        : D-cache request channel
//   write_d/wdata_d                         : D-cache write-back flag and block
//   data_valid_d/data_ready_d/data_d        : D-cache fill channel
//   l2_addr_valid/l2_addr_ready/l2_addr     : request to L2
//   l2_write/l2_wdata                       : write flag and block to L2
//   l2_data_valid/l2_data_ready/l2_data     : read response from L2
module l2_request_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int BLOCK_ADDRESS_WIDTH = l2_arbiter_pkg::BLOCK_ADDRESS_WIDTH,
    parameter int BLOCK_WIDTH         = l2_arbiter_pkg::BLOCK_WIDTH
) (
    input  logic                           clk,
    input  logic                           rst,

    input  logic                           addr_valid_i,
    output logic                           addr_ready_i,
    input  logic [BLOCK_ADDRESS_WIDTH-1:0] addr_i,
    output logic                           data_valid_i,
    input  logic                           data_ready_i,
    output logic [BLOCK_WIDTH-1:0]         data_i,

    input  logic                           addr_valid_d,
    output logic                           addr_ready_d,
    input  logic [BLOCK_ADDRESS_WIDTH-1:0] addr_d,
    input  logic                           write_d,
    input  logic [BLOCK_WIDTH-1:0]         wdata_d,
    output logic                           data_valid_d,
    input  logic                           data_ready_d,
    output logic [BLOCK_WIDTH-1:0]         data_d,

    output logic                           l2_addr_valid,
    input  logic                           l2_addr_ready,
    output logic [BLOCK_ADDRESS_WIDTH-1:0] l2_addr,
    output logic                           l2_write,
    output logic [BLOCK_WIDTH-1:0]         l2_wdata,
    input  logic                           l2_data_valid,
    output logic                           l2_data_ready,
    input  logic [BLOCK_WIDTH-1:0]         l2_data
);

    arb_state_e state_q, state_d;

    owner_e                         owner_q;
    logic [BLOCK_ADDRESS_WIDTH-1:0] addr_q;
    logic                           write_q;
    logic [BLOCK_WIDTH-1:0]         wdata_q;
    logic [BLOCK_WIDTH-1:0]         buffer_q;

    logic [1:0] grant;
    logic       hs_i, hs_d, hs_any;
    logic       owner_ready;

    round_robin_grant_2 u_grant (
        .clk    (clk),
        .rst    (rst),
        .req    ({addr_valid_d, addr_valid_i}),
        .update (hs_any),
        .grant  (grant)
    );

    // Ready is gated by rst as well so nothing is accepted while reset is held,
    // even though grant follows the raw valid inputs combinationally.
    assign addr_ready_i = (state_q == IDLE) & grant[0] & ~rst;
    assign addr_ready_d = (state_q == IDLE) & grant[1] & ~rst;
    assign hs_i         = addr_valid_i & addr_ready_i;
    assign hs_d         = addr_valid_d & addr_ready_d;
    assign hs_any       = hs_i | hs_d;

    assign owner_ready  = (owner_q == OWNER_D) ? data_ready_d : data_ready_i;

    // L2 request fields and fill data come straight from the transaction
    // registers, so they stay stable however long the other side stalls.
    assign l2_addr  = addr_q;
    assign l2_write = write_q;
    assign l2_wdata = wdata_q;
    assign data_i   = buffer_q;
    assign data_d   = buffer_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        l2_addr_valid = 1'b0;
        l2_data_ready = 1'b0;
        data_valid_i  = 1'b0;
        data_valid_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (hs_any) state_d = ISSUE;
            end
            ISSUE: begin
                l2_addr_valid = 1'b1;
                if (l2_addr_ready) state_d = write_q ? IDLE : WAIT_RESP;
            end
            WAIT_RESP: begin
                l2_data_ready = 1'b1;
                if (l2_data_valid) state_d = DELIVER;
            end
            DELIVER: begin
                data_valid_i = (owner_q == OWNER_I);
                data_valid_d = (owner_q == OWNER_D);
                if (owner_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the 512-bit block buffer is reset along with the other registers
    // because every output, the fill data included, must read 0 during reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner_q  <= OWNER_I;
            addr_q   <= '0;
            write_q  <= 1'b0;
            wdata_q  <= '0;
            buffer_q <= '0;
        end else begin
            if (hs_any) begin
                owner_q <= hs_d ? OWNER_D : OWNER_I;
                addr_q  <= hs_d ? addr_d : addr_i;
                write_q <= hs_d & write_d;
                wdata_q <= hs_d ? wdata_d : '0;
            end
            // Responses outside WAIT_RESP are dropped.
            if (state_q == WAIT_RESP && l2_data_valid) begin
                buffer_q <= l2_data;
            end
        end
    end

endmodule

// File: tb/tb_l2_request_arbiter.sv
// tb_l2_request_arbiter
// Directed bench for l2_request_arbiter. Expected L2 requests are queued when a
// cache request is driven and compared when L2 accepts them; expected fill
// blocks are queued when L2 accepts a read and compared on delivery.
module tb_l2_request_arbiter;
    import l2_arbiter_pkg::*;

    localparam int AW = BLOCK_ADDRESS_WIDTH;
    localparam int BW = BLOCK_WIDTH;

    logic          clk;
    logic          rst;
    logic          addr_valid_i, addr_ready_i;
    logic [AW-1:0] addr_i;
    logic          data_valid_i, data_ready_i;
    logic [BW-1:0] data_i;
    logic          addr_valid_d, addr_ready_d;
    logic [AW-1:0] addr_d;
    logic          write_d;
    logic [BW-1:0] wdata_d;
    logic          data_valid_d, data_ready_d;
    logic [BW-1:0] data_d;
    logic          l2_addr_valid, l2_addr_ready;
    logic [AW-1:0] l2_addr;
    logic          l2_write;
    logic [BW-1:0] l2_wdata;
    logic          l2_data_valid, l2_data_ready;
    logic [BW-1:0] l2_data;

    typedef struct {
        logic          owner;
        logic [AW-1:0] addr;
        logic          write;
        logic [BW-1:0] wdata;
    } l2_req_t;

    typedef struct {
        logic          owner;
        logic [BW-1:0] data;
    } fill_t;

    l2_req_t l2_q[$];
    fill_t   fill_q[$];

    int   vectors;
    int   miscompares;
    logic tb_last_d;  // 1 when the D-cache was granted last

    l2_request_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .addr_valid_i  (addr_valid_i),
        .addr_ready_i  (addr_ready_i),
        .addr_i        (addr_i),
        .data_valid_i  (data_valid_i),
        .data_ready_i  (data_ready_i),
        .data_i        (data_i),
        .addr_valid_d  (addr_valid_d),
        .addr_ready_d  (addr_ready_d),
        .addr_d        (addr_d),
        .write_d       (write_d),
        .wdata_d       (wdata_d),
        .data_valid_d  (data_valid_d),
        .data_ready_d  (data_ready_d),
        .data_d        (data_d),
        .l2_addr_valid (l2_addr_valid),
        .l2_addr_ready (l2_addr_ready),
        .l2_addr       (l2_addr),
        .l2_write      (l2_write),
        .l2_wdata      (l2_wdata),
        .l2_data_valid (l2_data_valid),
        .l2_data_ready (l2_data_ready),
        .l2_data       (l2_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] block_for(input logic [AW-1:0] a);
        logic [BW-1:0] b;
        for (int k = 0; k < 16; k++) begin
            b[k*32 +: 32] = ((32'(k) << 26) | 32'(a)) ^ 32'h5a5a_0f0f;
        end
        return b;
    endfunction

    function automatic logic [BW-1:0] pattern(input int seed);
        logic [BW-1:0] b;
        for (int k = 0; k < 16; k++) begin
            b[k*32 +: 32] = 32'hc0de_0000 ^ (32'(seed) << 8) ^ 32'(k);
        end
        return b;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive one IDLE-cycle request, check which cache is offered the grant,
    // queue the expected L2 request and let the handshake edge pass. Request
    // inputs are then scrambled to show the registered copy is what L2 sees.
    task automatic request(input logic vi, input logic vd,
                           input logic [AW-1:0] ai, input logic [AW-1:0] ad,
                           input logic wr, input logic [BW-1:0] wd);
        logic    exp_i, exp_d;
        l2_req_t e;
        addr_valid_i = vi;
        addr_valid_d = vd;
        addr_i       = ai;
        addr_d       = ad;
        write_d      = wr;
        wdata_d      = wd;
        #1;
        exp_i = (vi && vd) ? tb_last_d  : vi;
        exp_d = (vi && vd) ? !tb_last_d : vd;
        check("addr_ready_i", BW'(addr_ready_i), BW'(exp_i));
        check("addr_ready_d", BW'(addr_ready_d), BW'(exp_d));
        if (exp_i || exp_d) begin
            e.owner = exp_d;
            e.addr  = exp_d ? ad : ai;
            e.write = exp_d & wr;
            e.wdata = wd;
            l2_q.push_back(e);
            tb_last_d = exp_d;
        end
        step();
        addr_valid_i = 1'b0;
        addr_valid_d = 1'b0;
        addr_i       = ~ai;
        addr_d       = ~ad;
        write_d      = ~wr;
        wdata_d      = ~wd;
    endtask

    task automatic check_issue(input l2_req_t e);
        check("l2_addr_valid", BW'(l2_addr_valid), BW'(1'b1));
        check("l2_addr", BW'(l2_addr), BW'(e.addr));
        check("l2_write", BW'(l2_write), BW'(e.write));
        if (e.write) check("l2_wdata", l2_wdata, e.wdata);
        check("l2_data_ready_issue", BW'(l2_data_ready), BW'(1'b0));
    endtask

    // Act as L2 and the owning cache for the transaction just accepted, with
    // the given stall lengths on the L2 request, the response and the fill.
    task automatic serve(input int addr_stall, input int resp_delay, input int deliver_stall);
        l2_req_t e;
        fill_t   f;
        if (l2_q.size() == 0) begin
            vectors++;
            miscompares++;
            $error("FAIL serve_no_request observed=0 expected=1");
            return;
        end
        e = l2_q[0];
        for (int i = 0; i < addr_stall; i++) begin
            l2_addr_ready = 1'b0;
            l2_data_valid = 1'b1;  // stray response while issuing; must be ignored
            l2_data       = ~block_for(e.addr);
            #1;
            check_issue(e);
            step();
        end
        l2_data_valid = 1'b0;
        l2_addr_ready = 1'b1;
        #1;
        check_issue(e);
        e = l2_q.pop_front();
        if (!e.write) fill_q.push_back('{owner: e.owner, data: block_for(e.addr)});
        step();
        l2_addr_ready = 1'b0;
        if (e.write) begin
            #1;
            check("wr_done_l2_addr_valid", BW'(l2_addr_valid), BW'(1'b0));
            check("wr_no_data_valid_d", BW'(data_valid_d), BW'(1'b0));
            return;
        end
        for (int i = 0; i < resp_delay; i++) begin
            #1;
            check("l2_data_ready_wait", BW'(l2_data_ready), BW'(1'b1));
            check("l2_addr_valid_wait", BW'(l2_addr_valid), BW'(1'b0));
            step();
        end
        l2_data_valid = 1'b1;
        l2_data       = block_for(e.addr);
        #1;
        check("l2_data_ready", BW'(l2_data_ready), BW'(1'b1));
        step();
        l2_data_valid = 1'b0;
        l2_data       = pattern(99);
        f = fill_q.pop_front();
        for (int i = 0; i <= deliver_stall; i++) begin
            if (f.owner) data_ready_d = (i == deliver_stall);
            else         data_ready_i = (i == deliver_stall);
            #1;
            check("fill_valid_owner", BW'(f.owner ? data_valid_d : data_valid_i), BW'(1'b1));
            check("fill_valid_other", BW'(f.owner ? data_valid_i : data_valid_d), BW'(1'b0));
            check("fill_data", f.owner ? data_d : data_i, f.data);
            step();
        end
        data_ready_i = 1'b0;
        data_ready_d = 1'b0;
        #1;
        check("fill_once_i", BW'(data_valid_i), BW'(1'b0));
        check("fill_once_d", BW'(data_valid_d), BW'(1'b0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, BW'({addr_ready_i, addr_ready_d, data_valid_i, data_valid_d,
                                  l2_addr_valid, l2_data_ready, l2_write, l2_addr}), '0);
        check({tag, "_data_i"}, data_i, '0);
        check({tag, "_data_d"}, data_d, '0);
        check({tag, "_l2_wdata"}, l2_wdata, '0);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        tb_last_d     = 1'b1;
        rst           = 1'b1;
        addr_valid_i  = 1'b0;
        addr_valid_d  = 1'b0;
        addr_i        = '0;
        addr_d        = '0;
        write_d       = 1'b0;
        wdata_d       = '0;
        data_ready_i  = 1'b0;
        data_ready_d  = 1'b0;
        l2_addr_ready = 1'b0;
        l2_data_valid = 1'b0;
        l2_data       = '0;

        // Reset state, with both caches requesting to show ready stays low.
        step();
        addr_valid_i = 1'b1;
        addr_valid_d = 1'b1;
        #1;
        check_all_zero("reset");
        step();
        addr_valid_i = 1'b0;
        addr_valid_d = 1'b0;
        rst = 1'b0;
        step();

        // Single I read at minimum latency.
        request(1'b1, 1'b0, 26'h000_0002, 26'h0, 1'b0, '0);
        serve(0, 0, 0);

        // Simultaneous requests: grants alternate.
        for (int r = 0; r < 4; r++) begin
            request(1'b1, 1'b1, AW'(26'h100 + r), AW'(26'h200 + r), 1'b0, '0);
            serve(0, r % 2, 0);
        end

        // D write-backs back to back, then a D read with a stalled fill.
        request(1'b0, 1'b1, 26'h0, 26'h000_00a5, 1'b1, pattern(1));
        serve(0, 0, 0);
        request(1'b0, 1'b1, 26'h0, 26'h000_00a6, 1'b1, pattern(2));
        serve(2, 0, 0);
        request(1'b0, 1'b1, 26'h0, 26'h000_0077, 1'b0, '0);
        serve(0, 0, 2);

        // Backpressure on both the L2 request and the I-cache fill.
        request(1'b1, 1'b0, 26'h3ab_cdef, 26'h0, 1'b0, '0);
        serve(5, 1, 3);

        // Reset during WAIT_RESP abandons the transaction.
        request(1'b1, 1'b0, 26'h000_0044, 26'h0, 1'b0, '0);
        l2_addr_ready = 1'b1;
        step();
        l2_addr_ready = 1'b0;
        void'(l2_q.pop_front());
        check("pre_reset_wait_resp", BW'(l2_data_ready), BW'(1'b1));
        addr_valid_i = 1'b1;
        addr_valid_d = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("mid_reset");
        step();
        step();
        addr_valid_i = 1'b0;
        addr_valid_d = 1'b0;
        rst = 1'b0;
        tb_last_d = 1'b1;
        l2_q.delete();
        fill_q.delete();
        step();
        request(1'b1, 1'b1, 26'h000_0011, 26'h000_0022, 1'b0, '0);
        serve(0, 0, 0);
        request(1'b1, 1'b1, 26'h000_0011, 26'h000_0022, 1'b0, '0);
        serve(0, 0, 0);

        check("l2_q_empty", BW'(l2_q.size()), '0);
        check("fill_q_empty", BW'(fill_q.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/l2_request_arbiter.md
# l2_request_arbiter

- Shares the single L2 port between the instruction cache and the data cache.
- Accepts block requests from both caches and grants them round-robin, one outstanding L2 transaction at a time.
- Issues reads (block fills) and D-cache writes (block write-backs) to L2, buffers the returned 512-bit block and delivers it to the requester that owns the transaction.
- Sits between INSTRUCTION_CACHE / DATA_CACHE and the L2 model or cache.

## Interface

Parameters:
- BLOCK_ADDRESS_WIDTH, 26, block address width (32-bit byte address minus 6 offset bits)
- BLOCK_WIDTH, 512, 16 words x 32 bits

Ports:
- CLK  in  1  clock; one clock domain; everything is sampled on the rising edge
- RST  in  1  reset, asynchronous, active-high
- ADDR_VALID_I  in  1  I-cache request valid
- ADDR_READY_I  out  1  I-cache request accepted
- ADDR_I  in  BLOCK_ADDRESS_WIDTH  I-cache block address
- DATA_VALID_I  out  1  fill block valid to I-cache
- DATA_READY_I  in  1  I-cache ready for fill
- DATA_I  out  BLOCK_WIDTH  fill block
- ADDR_VALID_D / ADDR_READY_D / ADDR_D  same as the I-cache request channel, for the D-cache
- WRITE_D  in  1  D-cache request is a write-back
- WDATA_D  in  BLOCK_WIDTH  write-back block
- DATA_VALID_D / DATA_READY_D / DATA_D  same as the I-cache fill channel, for the D-cache
- L2_ADDR_VALID  out  1  request to L2
- L2_ADDR_READY  in  1  L2 accepts the request
- L2_ADDR  out  BLOCK_ADDRESS_WIDTH  block address to L2
- L2_WRITE  out  1  request is a write
- L2_WDATA  out  BLOCK_WIDTH  write block
- L2_DATA_VALID  in  1  read response valid
- L2_DATA_READY  out  1  arbiter ready for response
- L2_DATA  in  BLOCK_WIDTH  read response block

## Operation

FSM states: IDLE, ISSUE, WAIT_RESP, DELIVER.
- **IDLE**
  - Grant logic picks one requester among those with ADDR_VALID_x=1.
  - If both are valid, the one not granted last wins. The last-grant register resets to D, so I-cache wins the first tie.
  - ADDR_READY_x is combinational: (state==IDLE) & grant_x & !RST.
  - On the handshake, the arbiter registers the owner, address, write flag (WRITE_D; always 0 for I), and WDATA, updates last-grant, and moves to ISSUE.
- **ISSUE**
  - L2_ADDR_VALID=1, with L2_ADDR, L2_WRITE and L2_WDATA driven from the registers.
  - On L2_ADDR_READY with write=1: the write is complete and the FSM goes to IDLE. No response is expected and nothing is delivered to the D-cache.
  - On L2_ADDR_READY with write=0: go to WAIT_RESP.
- **WAIT_RESP**
  - L2_DATA_READY=1.
  - On L2_DATA_VALID, capture L2_DATA into the block buffer and go to DELIVER.
- **DELIVER**
  - DATA_VALID_owner=1 and DATA_owner=buffer; the other channel's valid stays 0.
  - On DATA_READY_owner, go to IDLE.
- L2_DATA_VALID outside WAIT_RESP is ignored; L2_DATA_READY is 0 there.
- Registered fields are stable for the whole transaction. Changes on ADDR_x/WDATA_D after acceptance have no effect.

## Timing

- Reset (RST high, asynchronous):
  - State goes to IDLE, last-grant to D, and buffer and registers to 0.
  - Every output is 0, including ADDR_READY_x.
  - Reset mid-transaction abandons it; L2 is reset by the same RST.
- Request accepted in cycle n → L2_ADDR_VALID from cycle n+1.
- Read, L2 accepts in n+1 and responds in n+2 → DATA_VALID_x in n+3. This is the minimum fill latency: 3 cycles from the request handshake.
- Write, L2 accepts in n+1 → IDLE in n+2, so the next request can be accepted in n+2.
- Back-to-back: at best one read per 4 cycles and one write per 2 cycles.
- Stalls:
  - L2_ADDR_READY low holds ISSUE indefinitely with stable outputs.
  - DATA_READY_x low holds DELIVER indefinitely.
- Simultaneous valid in IDLE: strict alternation. Neither requester waits more than one transaction.
- A requester deasserting ADDR_VALID before its handshake is legal; the grant is re-evaluated every IDLE cycle.

## Structure

- Package l2_arbiter_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT_RESP, DELIVER);
  - owner encoding OWNER_I=0, OWNER_D=1;
  - localparams BLOCK_ADDRESS_WIDTH=26, BLOCK_WIDTH=512.
- Sub-module round_robin_grant_2: two request inputs, last-grant register, one-hot grant output, and an update enable (the handshake). It is reusable for future requesters.
- Datapath (address, write flag, write data and response buffers) stays in the top module.

## Test plan

- **Single I read:** ADDR_I=0x0000002 requested, L2 ready=1, response one cycle after issue → L2_ADDR=0x0000002, L2_WRITE=0, DATA_VALID_I in cycle n+3 with the L2 block, DATA_VALID_D stays 0.
- **Simultaneous requests:** I and D valid in the same cycle, repeated 4 times → grants alternate I, D, I, D; L2_ADDR sequence matches.
- **D write-back:** WRITE_D=1, ADDR_D=0x00000A5, WDATA_D=pattern → L2_WRITE=1 with the pattern for one accepted cycle, no DATA_VALID_D, IDLE two cycles after acceptance.
- **Backpressure:** L2_ADDR_READY low for 5 cycles, then DATA_READY_I low for 3 cycles → outputs held stable throughout, block delivered exactly once.
- **Reset mid-transaction:** RST pulsed during WAIT_RESP → all outputs 0 asynchronously; after release, an I request followed by a D request → I granted first.
